// File: rtl/line_sequencer.sv
// Frame/line scan controller: sequences hsync, pixel-enable window and blanking
// for the free-running pixel counter across a configurable number of lines.
module line_sequencer #(
    parameter int PIX_W  = 8,
    parameter int LINE_W = 8,
    parameter int BLANK  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [PIX_W-1:0]  line_len,
    input  logic [LINE_W-1:0] num_lines,
    output logic              hsync,
    output logic              pix_en,
    output logic [PIX_W-1:0]  pix_idx,
    output logic [LINE_W-1:0] line_idx,
    output logic              busy,
    output logic              frame_done
);

    // state    | meaning
    // S_IDLE   | waiting for a start with non-zero configuration
    // S_SYNC   | one-cycle hsync at the head of a line
    // S_ACTIVE | pixel window, pix_idx counts 0..len-1
    // S_BLANK  | idle cycles between lines
    // S_DONE   | one-cycle frame_done pulse
    typedef enum logic [2:0] {
        S_IDLE,
        S_SYNC,
        S_ACTIVE,
        S_BLANK,
        S_DONE
    } state_t;

    localparam logic [15:0] BLANK_LOAD = 16'((BLANK > 0) ? BLANK - 1 : 0);

    state_t            state;
    state_t            state_nxt;
    logic [PIX_W-1:0]  len_q;
    logic [LINE_W-1:0] lines_q;
    logic [15:0]       blank_cnt;
    logic              start_ok;
    logic              pix_last;
    logic              line_last;
    logic              blank_last;

    assign start_ok   = start && (line_len != '0) && (num_lines != '0);
    assign pix_last   = (pix_idx == len_q - PIX_W'(1));
    assign line_last  = (line_idx == lines_q - LINE_W'(1));
    assign blank_last = (blank_cnt == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (start_ok) state_nxt = S_SYNC;
            S_SYNC:   state_nxt = S_ACTIVE;
            S_ACTIVE: begin
                if (pix_last) begin
                    if (line_last)      state_nxt = S_DONE;
                    else if (BLANK > 0) state_nxt = S_BLANK;
                    else                state_nxt = S_SYNC;
                end
            end
            S_BLANK:  if (blank_last) state_nxt = S_SYNC;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
        // abort overrides everything, including the DONE pulse that would follow
        if (abort) state_nxt = S_IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_q     <= '0;
            lines_q   <= '0;
            pix_idx   <= '0;
            line_idx  <= '0;
            blank_cnt <= '0;
        end else begin
            if (state == S_IDLE && state_nxt == S_SYNC) begin
                len_q   <= line_len;
                lines_q <= num_lines;
            end

            if (state_nxt == S_IDLE) begin
                pix_idx  <= '0;
                line_idx <= '0;
            end else if (state_nxt == S_SYNC) begin
                pix_idx <= '0;
                if (state != S_IDLE) line_idx <= line_idx + LINE_W'(1);
            end else if (state == S_ACTIVE && state_nxt == S_ACTIVE) begin
                pix_idx <= pix_idx + PIX_W'(1);
            end

            // blanking timer: down-counter loaded on entry, terminal at zero
            if (state_nxt == S_BLANK && state != S_BLANK) begin
                blank_cnt <= BLANK_LOAD;
            end else if (state == S_BLANK && !blank_last) begin
                blank_cnt <= blank_cnt - 16'd1;
            end
        end
    end

    assign hsync      = (state == S_SYNC);
    assign pix_en     = (state == S_ACTIVE);
    assign busy       = (state != S_IDLE);
    assign frame_done = (state == S_DONE);

endmodule

// File: tb/tb_line_sequencer.sv
// Bench for line_sequencer: expected per-cycle outputs are generated from the
// frame structure and compared against two instances (BLANK=4 and BLANK=0).
module tb_line_sequencer;

    typedef struct packed {
        logic       hsync;
        logic       pix_en;
        logic [7:0] pix_idx;
        logic [7:0] line_idx;
        logic       busy;
        logic       frame_done;
    } obs_t;

    typedef struct {
        int len;
        int lines;
        bit ok;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst, start, start0, abort;
    logic [7:0] line_len, num_lines;
    logic       hsync, pix_en, busy, frame_done;
    logic [7:0] pix_idx, line_idx;
    logic       hsync0, pix_en0, busy0, frame_done0;
    logic [7:0] pix_idx0, line_idx0;

    obs_t exp_q[$];
    obs_t exp0_q[$];
    int   total = 0;
    int   bad   = 0;
    localparam obs_t IDLE_OBS = '{1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0};

    always #5 clk = ~clk;

    line_sequencer #(.PIX_W(8), .LINE_W(8), .BLANK(4)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .line_len(line_len), .num_lines(num_lines),
        .hsync(hsync), .pix_en(pix_en), .pix_idx(pix_idx), .line_idx(line_idx),
        .busy(busy), .frame_done(frame_done)
    );

    line_sequencer #(.PIX_W(8), .LINE_W(8), .BLANK(0)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .abort(abort),
        .line_len(line_len), .num_lines(num_lines),
        .hsync(hsync0), .pix_en(pix_en0), .pix_idx(pix_idx0), .line_idx(line_idx0),
        .busy(busy0), .frame_done(frame_done0)
    );

    function automatic obs_t cur();
        return '{hsync, pix_en, pix_idx, line_idx, busy, frame_done};
    endfunction

    function automatic obs_t cur0();
        return '{hsync0, pix_en0, pix_idx0, line_idx0, busy0, frame_done0};
    endfunction

    function automatic obs_t mk(logic h, logic p, int pi, int li, logic b, logic fd);
        return '{h, p, 8'(pi), 8'(li), b, fd};
    endfunction

    function automatic void push(int which, obs_t r);
        if (which == 0) exp_q.push_back(r);
        else            exp0_q.push_back(r);
    endfunction

    // one SYNC, len ACTIVE, blank BLANK per line (no blank after the last), then DONE
    function automatic void push_frame(int which, int len, int lines, int blank);
        for (int l = 0; l < lines; l++) begin
            push(which, mk(1, 0, 0, l, 1, 0));
            for (int p = 0; p < len; p++) push(which, mk(0, 1, p, l, 1, 0));
            if (l < lines - 1)
                for (int b = 0; b < blank; b++) push(which, mk(0, 0, len - 1, l, 1, 0));
        end
        push(which, mk(0, 0, len - 1, lines - 1, 1, 1));
    endfunction

    task automatic check(input string name, input obs_t got, input obs_t exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got hs=%b en=%b pix=%0d line=%0d busy=%b done=%b, want hs=%b en=%b pix=%0d line=%0d busy=%b done=%b",
                     name, got.hsync, got.pix_en, got.pix_idx, got.line_idx, got.busy, got.frame_done,
                     exp.hsync, exp.pix_en, exp.pix_idx, exp.line_idx, exp.busy, exp.frame_done);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // kind 1: drop both starts after tick evt_t; kind 2: drop start after tick 1,
    // then pulse start with different config at tick evt_t
    task automatic run_q(input int maxc, input int evt_t, input int kind);
        int t = 0;
        while ((exp_q.size() > 0 || exp0_q.size() > 0) && t < maxc) begin
            tick();
            t++;
            if (exp_q.size() > 0)  check("seq", cur(), exp_q.pop_front());
            if (exp0_q.size() > 0) check("seq0", cur0(), exp0_q.pop_front());
            if (kind == 1 && t == evt_t) begin
                start  = 1'b0;
                start0 = 1'b0;
            end
            if (kind == 2) begin
                if (t == 1) start = 1'b0;
                if (t == evt_t) begin
                    start     = 1'b1;
                    line_len  = 8'd7;
                    num_lines = 8'd5;
                end
                if (t == evt_t + 1) start = 1'b0;
            end
        end
        total++;
        if (exp_q.size() > 0 || exp0_q.size() > 0) begin
            bad++;
            $display("FAIL timeout pending=%0d/%0d after %0d cycles", exp_q.size(), exp0_q.size(), t);
            exp_q.delete();
            exp0_q.delete();
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[5];
        vecs[0] = '{5, 3, 1'b1};
        vecs[1] = '{0, 3, 1'b0};
        vecs[2] = '{4, 0, 1'b0};
        vecs[3] = '{1, 1, 1'b1};
        vecs[4] = '{2, 2, 1'b1};

        rst = 1'b1; start = 1'b0; start0 = 1'b0; abort = 1'b0;
        line_len = 8'd0; num_lines = 8'd0;
        repeat (2) @(negedge clk);
        check("reset", cur(), IDLE_OBS);
        check("reset0", cur0(), IDLE_OBS);
        rst = 1'b0;
        tick();
        check("idle_after_reset", cur(), IDLE_OBS);

        for (int i = 0; i < 5; i++) begin
            line_len  = 8'(vecs[i].len);
            num_lines = 8'(vecs[i].lines);
            start     = 1'b1;
            if (vecs[i].ok) begin
                push_frame(0, vecs[i].len, vecs[i].lines, 4);
                push(0, IDLE_OBS);
            end else begin
                repeat (3) push(0, IDLE_OBS);
            end
            run_q(500, 1, 1);
        end

        // BLANK=0: hsync, pix_en, hsync, pix_en, frame_done back to back
        line_len = 8'd1; num_lines = 8'd2; start0 = 1'b1;
        push_frame(1, 1, 2, 0);
        push(1, IDLE_OBS);
        run_q(50, 1, 1);

        // start during ACTIVE must not disturb the running frame
        line_len = 8'd4; num_lines = 8'd2; start = 1'b1;
        push_frame(0, 4, 2, 4);
        push(0, IDLE_OBS);
        run_q(200, 3, 2);
        repeat (2) push(0, IDLE_OBS);
        run_q(10, 0, 0);

        // abort in the second line's blanking
        line_len = 8'd3; num_lines = 8'd3; start = 1'b1;
        push_frame(0, 3, 3, 4);
        while (exp_q.size() > 14) void'(exp_q.pop_back());
        run_q(100, 1, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_blank", cur(), IDLE_OBS);
        for (int i = 0; i < 30; i++) begin
            tick();
            check("abort_quiet", cur(), IDLE_OBS);
        end

        // abort together with start in IDLE
        line_len = 8'd5; num_lines = 8'd3; start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        check("abort_start", cur(), IDLE_OBS);
        tick();
        check("abort_start_hold", cur(), IDLE_OBS);

        // abort on the final pixel suppresses frame_done
        line_len = 8'd2; num_lines = 8'd1; start = 1'b1;
        push_frame(0, 2, 1, 4);
        while (exp_q.size() > 3) void'(exp_q.pop_back());
        run_q(20, 1, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_last_pix", cur(), IDLE_OBS);

        // asynchronous reset in the middle of ACTIVE
        line_len = 8'd8; num_lines = 8'd3; start = 1'b1;
        push_frame(0, 8, 3, 4);
        while (exp_q.size() > 4) void'(exp_q.pop_back());
        run_q(20, 1, 1);
        rst = 1'b1;
        #1;
        check("async_reset", cur(), IDLE_OBS);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("post_reset_idle", cur(), IDLE_OBS);
        end

        // back-to-back frames with start held, longest line
        line_len = 8'd255; num_lines = 8'd2; start = 1'b1;
        push_frame(0, 255, 2, 4);
        push(0, IDLE_OBS);
        push_frame(0, 255, 2, 4);
        push(0, IDLE_OBS);
        run_q(2000, 600, 1);

        // longest frame in lines on the BLANK=0 instance
        line_len = 8'd1; num_lines = 8'd255; start0 = 1'b1;
        push_frame(1, 1, 255, 0);
        push(1, IDLE_OBS);
        run_q(1000, 1, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
